// File: rtl/mmio_csr_bank_if.sv
// MMIO request/response bundle for mmio_csr_bank.
// Request side: write/read strobes, dword address, length, TID, write data.
// Response side: read response strobe, echoed TID, read data.
interface mmio_csr_bank_if;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [1:0]  mmio_len;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;
  logic        rd_rsp_valid;
  logic [8:0]  rd_rsp_tid;
  logic [63:0] rd_rsp_data;

  // Host side: issues requests, receives read responses.
  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
    input  rd_rsp_valid, rd_rsp_tid, rd_rsp_data
  );

  // CSR bank side: consumes requests, returns read responses.
  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_len, mmio_tid, mmio_wdata,
    output rd_rsp_valid, rd_rsp_tid, rd_rsp_data
  );
endinterface

// File: rtl/mmio_csr_bank.sv
// MMIO CSR bank: DFH / AFU ID header, free-running cycle counter, W1C error
// register and NUM_REGS 64-bit scratch registers, with a fixed-latency read
// response pipeline.
// Ports:
//   Clk_400     - core clock, rising edge
//   SoftReset_n - asynchronous active-low reset
//   bus         - MMIO request/response bundle (slave side)
//   scratch_q   - all scratch registers, register k at [64k+63:64k]
module mmio_csr_bank #(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned RD_LATENCY  = 1,
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter logic [63:0] AFU_ID_H    = 64'h0,
  parameter logic [63:0] SCRATCH_RST = 64'h0
) (
  input  logic                      Clk_400,
  input  logic                      SoftReset_n,
  mmio_csr_bank_if.slave            bus,
  output logic [64*NUM_REGS-1:0]    scratch_q
);

  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [15:0] A_DFH   = 16'h0000;
  localparam logic [15:0] A_IDL   = 16'h0002;
  localparam logic [15:0] A_IDH   = 16'h0004;
  localparam logic [15:0] A_NEXT  = 16'h0006;
  localparam logic [15:0] A_RSVD  = 16'h0008;
  localparam logic [15:0] A_CYC   = 16'h0010;
  localparam logic [15:0] A_ERR   = 16'h0012;
  localparam logic [15:0] A_SCR   = 16'h0020;
  localparam logic [15:0] SCR_END = 16'(32 + 2 * NUM_REGS);
  localparam logic [63:0] DFH_VAL = 64'h1000_0100_0000_0000;

  logic [63:0]      scratch [NUM_REGS];
  logic [63:0]      cycle_q;
  logic [1:0]       err_q;
  logic             pipe_vld  [RD_LATENCY];
  logic [8:0]       pipe_tid  [RD_LATENCY];
  logic [63:0]      pipe_data [RD_LATENCY];

  logic [15:0]      dw_addr;
  logic [15:0]      scr_off;
  logic [IDX_W-1:0] scr_idx;
  logic             hi_dw;
  logic             acc_4b;
  logic             acc_8b;
  logic             hit_dfh, hit_idl, hit_idh, hit_zero, hit_cyc, hit_err, hit_scr;
  logic             mapped;
  logic             wr_go;
  logic [63:0]      rd_word;
  logic [63:0]      rd_data_c;
  logic [1:0]       err_set;
  logic [1:0]       err_clr;

  // Address decode, read mux and write/error qualification.
  always_comb begin
    dw_addr   = {bus.mmio_addr[15:1], 1'b0};
    hi_dw     = bus.mmio_addr[0];
    acc_4b    = (bus.mmio_len == 2'd0);
    acc_8b    = (bus.mmio_len == 2'd1);
    scr_off   = dw_addr - A_SCR;
    scr_idx   = IDX_W'(scr_off[15:1]);
    hit_dfh   = (dw_addr == A_DFH);
    hit_idl   = (dw_addr == A_IDL);
    hit_idh   = (dw_addr == A_IDH);
    hit_zero  = (dw_addr == A_NEXT) || (dw_addr == A_RSVD);
    hit_cyc   = (dw_addr == A_CYC);
    hit_err   = (dw_addr == A_ERR);
    hit_scr   = (dw_addr >= A_SCR) && (dw_addr < SCR_END);
    // 8 B accesses must be dword-pair aligned; lengths 2/3 never map.
    mapped    = (acc_4b || (acc_8b && !hi_dw)) &&
                (hit_dfh || hit_idl || hit_idh || hit_zero || hit_cyc || hit_err || hit_scr);

    rd_word = 64'h0;
    if (hit_dfh)      rd_word = DFH_VAL;
    else if (hit_idl) rd_word = AFU_ID_L;
    else if (hit_idh) rd_word = AFU_ID_H;
    else if (hit_cyc) rd_word = cycle_q;
    else if (hit_err) rd_word = {62'h0, err_q};
    else if (hit_scr) rd_word = scratch[scr_idx];

    // 4 B reads replicate the selected dword into both halves.
    rd_data_c = 64'h0;
    if (mapped) begin
      if (acc_4b) rd_data_c = hi_dw ? {2{rd_word[63:32]}} : {2{rd_word[31:0]}};
      else        rd_data_c = rd_word;
    end

    // A write colliding with a read is dropped.
    wr_go   = bus.mmio_wr_valid && !bus.mmio_rd_valid && mapped;
    err_set = {bus.mmio_wr_valid && bus.mmio_rd_valid,
               (bus.mmio_wr_valid || bus.mmio_rd_valid) && !mapped};
    // Only the low dword of ERR holds bits; a high-dword 4 B write clears nothing.
    err_clr = (wr_go && hit_err && !hi_dw) ? bus.mmio_wdata[1:0] : 2'b00;
  end

  // Cycle counter and W1C error register; set beats clear.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      cycle_q <= 64'h0;
      err_q   <= 2'b00;
    end else begin
      cycle_q <= (wr_go && hit_cyc) ? 64'h0 : cycle_q + 64'd1;
      err_q   <= (err_q & ~err_clr) | err_set;
    end
  end

  // Scratch registers; 4 B writes merge wdata[31:0] into the selected dword.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      for (int i = 0; i < NUM_REGS; i++) scratch[i] <= SCRATCH_RST;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_go && hit_scr && (scr_idx == IDX_W'(i))) begin
          if (acc_8b)     scratch[i]         <= bus.mmio_wdata;
          else if (hi_dw) scratch[i][63:32]  <= bus.mmio_wdata[31:0];
          else            scratch[i][31:0]   <= bus.mmio_wdata[31:0];
        end
      end
    end
  end

  // Read response pipeline: data captured on the request edge, emerges RD_LATENCY cycles later.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_tid[i]  <= 9'h0;
        pipe_data[i] <= 64'h0;
      end
    end else begin
      pipe_vld[0]  <= bus.mmio_rd_valid;
      pipe_tid[0]  <= bus.mmio_tid;
      pipe_data[0] <= rd_data_c;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_tid[i]  <= pipe_tid[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign bus.rd_rsp_valid = pipe_vld[RD_LATENCY-1];
  assign bus.rd_rsp_tid   = pipe_tid[RD_LATENCY-1];
  assign bus.rd_rsp_data  = pipe_data[RD_LATENCY-1];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign scratch_q[64*g +: 64] = scratch[g];
  end

endmodule

// File: tb/tb_mmio_csr_bank.sv
// Directed self-checking bench for mmio_csr_bank. Two instances (read latency
// 3 and 4) receive identical requests; responses are logged with the cycle
// they appear in and compared against hand-computed expectations.
module tb_mmio_csr_bank;

  localparam logic [63:0] ID_L  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] RST_V = 64'h5A5A_0000_0000_A5A5;
  localparam logic [63:0] DFH   = 64'h1000_0100_0000_0000;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, rd_valid;
  logic [15:0] addr;
  logic [1:0]  len;
  logic [8:0]  tid;
  logic [63:0] wdata;
  logic [255:0] sq3, sq4;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  rsp_t        rq3[$], rq4[$], expq[$];

  mmio_csr_bank_if if3 ();
  mmio_csr_bank_if if4 ();

  assign if3.mmio_wr_valid = wr_valid;
  assign if3.mmio_rd_valid = rd_valid;
  assign if3.mmio_addr     = addr;
  assign if3.mmio_len      = len;
  assign if3.mmio_tid      = tid;
  assign if3.mmio_wdata    = wdata;
  assign if4.mmio_wr_valid = wr_valid;
  assign if4.mmio_rd_valid = rd_valid;
  assign if4.mmio_addr     = addr;
  assign if4.mmio_len      = len;
  assign if4.mmio_tid      = tid;
  assign if4.mmio_wdata    = wdata;

  mmio_csr_bank #(
    .NUM_REGS(4), .RD_LATENCY(3), .AFU_ID_L(ID_L), .AFU_ID_H(ID_H), .SCRATCH_RST(RST_V)
  ) u_dut (
    .Clk_400(clk), .SoftReset_n(rst_n), .bus(if3.slave), .scratch_q(sq3)
  );

  mmio_csr_bank #(
    .NUM_REGS(4), .RD_LATENCY(4), .AFU_ID_L(ID_L), .AFU_ID_H(ID_H), .SCRATCH_RST(RST_V)
  ) u_dut4 (
    .Clk_400(clk), .SoftReset_n(rst_n), .bus(if4.slave), .scratch_q(sq4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every response with the cycle it is visible in.
  always @(negedge clk) begin
    rsp_t r;
    if (if3.rd_rsp_valid === 1'b1) begin
      r.tid = if3.rd_rsp_tid; r.data = if3.rd_rsp_data; r.cyc = cyc;
      rq3.push_back(r);
    end
    if (if4.rd_rsp_valid === 1'b1) begin
      r.tid = if4.rd_rsp_tid; r.data = if4.rd_rsp_data; r.cyc = cyc;
      rq4.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_req(input logic [15:0] a, input logic [1:0] l, input logic [63:0] d);
    wr_valid = 1'b1; addr = a; len = l; wdata = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd_req(input logic [15:0] a, input logic [1:0] l, input logic [8:0] t,
                        input logic [63:0] exp);
    rsp_t e;
    rd_valid = 1'b1; addr = a; len = l; tid = t;
    e.tid = t; e.data = exp; e.cyc = cyc;
    expq.push_back(e);
    tick();
    rd_valid = 1'b0;
  endtask

  // Compare logged responses with expectations: count, order, TID, data, latency.
  task automatic drain();
    repeat (6) tick();
    chk("rsp_count_lat3", 64'(rq3.size()), 64'(expq.size()));
    chk("rsp_count_lat4", 64'(rq4.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < rq3.size()) begin
        chk($sformatf("tid_lat3_t%0h", expq[i].tid), 64'(rq3[i].tid), 64'(expq[i].tid));
        chk($sformatf("data_lat3_t%0h", expq[i].tid), rq3[i].data, expq[i].data);
        chk($sformatf("cyc_lat3_t%0h", expq[i].tid), 64'(rq3[i].cyc), 64'(expq[i].cyc + 3));
      end
      if (i < rq4.size()) begin
        chk($sformatf("tid_lat4_t%0h", expq[i].tid), 64'(rq4[i].tid), 64'(expq[i].tid));
        chk($sformatf("data_lat4_t%0h", expq[i].tid), rq4[i].data, expq[i].data);
        chk($sformatf("cyc_lat4_t%0h", expq[i].tid), 64'(rq4[i].cyc), 64'(expq[i].cyc + 4));
      end
    end
    expq.delete();
    rq3.delete();
    rq4.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0; rd_valid = 1'b0;
    addr = 16'h0; len = 2'd0; tid = 9'h0; wdata = 64'h0;
    repeat (3) tick();
    chk("rst_valid", 64'(if3.rd_rsp_valid), 64'h0);
    chk("rst_tid", 64'(if3.rd_rsp_tid), 64'h0);
    chk("rst_data", if3.rd_rsp_data, 64'h0);
    chk("rst_scratch", sq3[63:0], RST_V);
    chk("rst_scratch3", sq3[255:192], RST_V);
    rst_n = 1'b1;

    // Counter starts at 0 out of reset and steps by one per cycle.
    rd_req(16'h0010, 2'd1, 9'h001, 64'd0);
    rd_req(16'h0010, 2'd1, 9'h002, 64'd1);
    // Header registers, 8 B and 4 B.
    rd_req(16'h0002, 2'd1, 9'h015, ID_L);
    rd_req(16'h0000, 2'd1, 9'h016, DFH);
    rd_req(16'h0004, 2'd0, 9'h017, 64'h7654_3210_7654_3210);
    rd_req(16'h0005, 2'd0, 9'h018, 64'hFEDC_BA98_FEDC_BA98);
    rd_req(16'h0006, 2'd1, 9'h019, 64'h0);
    rd_req(16'h0008, 2'd1, 9'h01A, 64'h0);
    rd_req(16'h0012, 2'd1, 9'h01B, 64'h0);
    drain();

    // Scratch: 8 B write, 4 B high-dword merge, immediate read-back.
    wr_req(16'h0022, 2'd1, 64'hDEAD_BEEF_CAFE_F00D);
    wr_req(16'h0023, 2'd0, 64'hFFFF_FFFF_1234_5678);
    rd_req(16'h0022, 2'd1, 9'h020, 64'h1234_5678_CAFE_F00D);
    rd_req(16'h0023, 2'd0, 9'h021, 64'h1234_5678_1234_5678);
    wr_req(16'h0024, 2'd0, 64'hAAAA_AAAA_0000_1111);
    rd_req(16'h0024, 2'd1, 9'h022, 64'h5A5A_0000_0000_1111);
    chk("sq_reg1", sq3[127:64], 64'h1234_5678_CAFE_F00D);
    chk("sq_reg0", sq3[63:0], RST_V);
    chk("sq_reg2", sq3[191:128], 64'h5A5A_0000_0000_1111);
    drain();

    // Three back-to-back reads in order.
    rd_req(16'h0000, 2'd1, 9'h001, DFH);
    rd_req(16'h0004, 2'd1, 9'h002, ID_H);
    rd_req(16'h0020, 2'd1, 9'h003, RST_V);
    drain();

    // Unmapped accesses set ERR[0]; W1C clears it.
    rd_req(16'h0040, 2'd1, 9'h030, 64'h0);
    rd_req(16'h0012, 2'd1, 9'h031, 64'h1);
    wr_req(16'h0012, 2'd1, 64'h1);
    rd_req(16'h0012, 2'd1, 9'h032, 64'h0);
    rd_req(16'h0023, 2'd1, 9'h033, 64'h0);
    rd_req(16'h0012, 2'd1, 9'h034, 64'h1);
    wr_req(16'h0012, 2'd1, 64'h1);
    rd_req(16'h0020, 2'd2, 9'h035, 64'h0);
    wr_req(16'h0012, 2'd1, 64'h1);
    wr_req(16'h0027, 2'd1, 64'h1111_2222_3333_4444);
    chk("unmapped_wr_reg3", sq3[255:192], RST_V);
    rd_req(16'h0012, 2'd1, 9'h036, 64'h1);
    wr_req(16'h0012, 2'd1, 64'h3);
    drain();

    // Collision: read sees old value, write dropped, ERR[1] set.
    rd_valid = 1'b1; wr_valid = 1'b1;
    addr = 16'h0020; len = 2'd1; tid = 9'h040; wdata = 64'h1111;
    begin
      rsp_t e;
      e.tid = 9'h040; e.data = RST_V; e.cyc = cyc;
      expq.push_back(e);
    end
    tick();
    rd_valid = 1'b0; wr_valid = 1'b0;
    chk("collide_scratch", sq3[63:0], RST_V);
    rd_req(16'h0012, 2'd1, 9'h041, 64'h2);
    wr_req(16'h0012, 2'd1, 64'h2);
    rd_req(16'h0012, 2'd1, 9'h042, 64'h0);
    drain();

    // Writing CYCLE zeroes it; counting resumes next edge.
    wr_req(16'h0010, 2'd1, 64'hFFFF_0000_FFFF_0000);
    rd_req(16'h0010, 2'd1, 9'h050, 64'd0);
    rd_req(16'h0010, 2'd1, 9'h051, 64'd1);
    drain();

    // One-cycle reset during a pending read: no response, state restored.
    rd_valid = 1'b1; addr = 16'h0002; len = 2'd1; tid = 9'h033;
    tick();
    rd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_scratch1", sq3[127:64], RST_V);
    chk("async_rst_scratch2_lat4", sq4[191:128], RST_V);
    chk("async_rst_valid_lat4", 64'(if4.rd_rsp_valid), 64'h0);
    tick();
    rst_n = 1'b1;
    rd_req(16'h0010, 2'd1, 9'h060, 64'd0);
    rd_req(16'h0012, 2'd1, 9'h061, 64'h0);
    drain();
    chk("post_rst_scratch1", sq3[127:64], RST_V);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
